// File: rtl/rf_scoreboard_if.sv
// rf_scoreboard_if: decode-issue / writeback / flush bundle for the RAW hazard scoreboard.
interface rf_scoreboard_if;
   logic       issue_valid;
   logic       issue_write;
   logic [2:0] issue_dst;
   logic       src1_use;
   logic       src2_use;
   logic [2:0] src1_sel;
   logic [2:0] src2_sel;
   logic       wb_write;
   logic [2:0] wb_sel;
   logic       flush;
   logic       stall;
   logic [7:0] pending;
   logic       err;
   modport master (
      output issue_valid, issue_write, issue_dst, src1_use, src2_use, src1_sel, src2_sel,
             wb_write, wb_sel, flush,
      input  stall, pending, err
   );
   modport slave (
      input  issue_valid, issue_write, issue_dst, src1_use, src2_use, src1_sel, src2_sel,
             wb_write, wb_sel, flush,
      output stall, pending, err
   );
endinterface

// File: rtl/rf_scoreboard.sv
// rf_scoreboard: per-register in-flight write counters that stall issue on RAW hazards.
module rf_scoreboard (
   input logic          clk,
   input logic          rst,
   rf_scoreboard_if.slave sb
);
   logic [1:0] count [8];
   logic [1:0] eff   [8];
   logic [1:0] nxt   [8];
   logic [7:0] ret;
   logic [7:0] pend_d;
   logic [7:0] pend_q;
   logic       stall_c;
   logic       fire;
   // eff is the count after this cycle's writeback, which the register file bypass covers
   always_comb begin
      for (int r = 0; r < 8; r++) begin
         ret[r] = sb.wb_write && sb.wb_sel == 3'(r) && count[r] != 2'd0;
         eff[r] = count[r] - {1'b0, ret[r]};
      end
      stall_c = sb.issue_valid && !sb.flush &&
                ((sb.src1_use && eff[sb.src1_sel] != 2'd0) ||
                 (sb.src2_use && eff[sb.src2_sel] != 2'd0) ||
                 (sb.issue_write && eff[sb.issue_dst] == 2'd3));
      fire = sb.issue_valid && !stall_c && !sb.flush;
      for (int r = 0; r < 8; r++) begin
         nxt[r] = sb.flush ? 2'd0 :
                  count[r] + {1'b0, fire && sb.issue_write && sb.issue_dst == 3'(r)} - {1'b0, ret[r]};
         pend_d[r] = nxt[r] != 2'd0;
      end
   end
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         count  <= '{default: 2'd0};
         pend_q <= 8'h00;
      end else begin
         count  <= nxt;
         pend_q <= pend_d;
      end
   end
   assign sb.stall   = stall_c;
   assign sb.err     = sb.wb_write && count[sb.wb_sel] == 2'd0 && !sb.flush;
   assign sb.pending = pend_q;
endmodule

// File: tb/tb_rf_scoreboard.sv
// tb_rf_scoreboard: directed table plus randomized traffic against a counting model.
module tb_rf_scoreboard;
   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   rf_scoreboard_if sb ();
   rf_scoreboard dut (.clk(clk), .rst(rst), .sb(sb));

   typedef struct {
      logic       iv, iw;
      logic [2:0] dst;
      logic       u1;
      logic [2:0] s1;
      logic       u2;
      logic [2:0] s2;
      logic       wbw;
      logic [2:0] wbs;
      logic       fl;
      logic       st, er;
      logic [7:0] pd;
   } vec_t;

   int checks = 0;
   int failures = 0;
   int cnt [8];
   vec_t tbl [$];

   function automatic vec_t mk(logic iv, logic iw, logic [2:0] dst, logic u1, logic [2:0] s1,
                               logic u2, logic [2:0] s2, logic wbw, logic [2:0] wbs, logic fl,
                               logic st, logic er, logic [7:0] pd);
      vec_t v;
      v.iv = iv; v.iw = iw; v.dst = dst; v.u1 = u1; v.s1 = s1; v.u2 = u2; v.s2 = s2;
      v.wbw = wbw; v.wbs = wbs; v.fl = fl; v.st = st; v.er = er; v.pd = pd;
      return v;
   endfunction

   task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic drive(input vec_t v);
      sb.issue_valid = v.iv; sb.issue_write = v.iw; sb.issue_dst = v.dst;
      sb.src1_use = v.u1; sb.src1_sel = v.s1; sb.src2_use = v.u2; sb.src2_sel = v.s2;
      sb.wb_write = v.wbw; sb.wb_sel = v.wbs; sb.flush = v.fl;
   endtask

   function automatic logic [7:0] model_pending();
      logic [7:0] p;
      for (int r = 0; r < 8; r++) p[r] = cnt[r] > 0;
      return p;
   endfunction

   // One clock: compare combinational outputs mid-cycle, advance the model, compare pending after the edge.
   task automatic step(input vec_t v, input bit use_tbl, input string tag);
      bit retire, st, er;
      int e [8];
      drive(v);
      @(negedge clk);
      retire = v.wbw && cnt[v.wbs] > 0;
      for (int r = 0; r < 8; r++) e[r] = cnt[r] - ((retire && v.wbs == 3'(r)) ? 1 : 0);
      st = v.iv && !v.fl && ((v.u1 && e[v.s1] > 0) || (v.u2 && e[v.s2] > 0) || (v.iw && e[v.dst] == 3));
      er = v.wbw && cnt[v.wbs] == 0 && !v.fl;
      chk({tag, ".stall"}, {7'd0, sb.stall}, {7'd0, st});
      chk({tag, ".err"}, {7'd0, sb.err}, {7'd0, er});
      if (use_tbl) begin
         chk({tag, ".stall_tbl"}, {7'd0, sb.stall}, {7'd0, v.st});
         chk({tag, ".err_tbl"}, {7'd0, sb.err}, {7'd0, v.er});
      end
      if (v.fl) cnt = '{default: 0};
      else begin
         cnt = e;
         if (v.iv && !st && v.iw) cnt[v.dst]++;
      end
      @(posedge clk);
      #1;
      chk({tag, ".pending"}, sb.pending, model_pending());
      if (use_tbl) chk({tag, ".pending_tbl"}, sb.pending, v.pd);
   endtask

   initial begin
      vec_t v;
      cnt = '{default: 0};
      drive(mk(0,0,0,0,0,0,0,0,0,0,0,0,0));
      #2;
      chk("reset.pending", sb.pending, 8'h00);
      chk("reset.stall", {7'd0, sb.stall}, 8'h00);
      chk("reset.err", {7'd0, sb.err}, 8'h00);
      @(posedge clk); #1;
      rst = 1'b0;

      // Three writes to r2, then reset mid-stream with a reader of r2 presented
      for (int i = 0; i < 3; i++) step(mk(1,1,2,0,0,0,0,0,0,0, 0,0,8'h04), 1, "w2");
      drive(mk(1,0,0,1,2,0,0,0,0,0,0,0,0));
      #1;
      chk("midrst.pre_stall", {7'd0, sb.stall}, 8'h01);
      rst = 1'b1;
      #1;
      cnt = '{default: 0};
      chk("midrst.pending", sb.pending, 8'h00);
      chk("midrst.stall", {7'd0, sb.stall}, 8'h00);
      #1 rst = 1'b0;
      step(mk(1,0,0,1,2,0,0,0,0,0, 0,0,8'h00), 1, "postrst_read2");

      //        iv iw dst u1 s1 u2 s2 wbw wbs fl  st er pd
      tbl.push_back(mk(1,1,3, 0,0, 0,0, 0,0, 0, 0,0,8'h08));
      tbl.push_back(mk(1,0,0, 1,3, 0,0, 0,0, 0, 1,0,8'h08));
      tbl.push_back(mk(1,0,0, 1,3, 0,0, 1,3, 0, 0,0,8'h00));
      tbl.push_back(mk(1,1,5, 0,0, 0,0, 0,0, 0, 0,0,8'h20));
      tbl.push_back(mk(1,1,5, 0,0, 0,0, 0,0, 0, 0,0,8'h20));
      tbl.push_back(mk(1,1,5, 0,0, 0,0, 0,0, 0, 0,0,8'h20));
      tbl.push_back(mk(1,1,5, 0,0, 0,0, 0,0, 0, 1,0,8'h20));
      tbl.push_back(mk(1,1,5, 0,0, 0,0, 1,5, 0, 0,0,8'h20));
      tbl.push_back(mk(0,0,0, 0,0, 0,0, 1,5, 0, 0,0,8'h20));
      tbl.push_back(mk(0,0,0, 0,0, 0,0, 1,5, 0, 0,0,8'h20));
      tbl.push_back(mk(0,0,0, 0,0, 0,0, 1,5, 0, 0,0,8'h00));
      tbl.push_back(mk(1,1,1, 0,0, 0,0, 0,0, 0, 0,0,8'h02));
      tbl.push_back(mk(1,1,1, 0,0, 0,0, 1,1, 0, 0,0,8'h02));
      tbl.push_back(mk(0,0,0, 0,0, 0,0, 1,1, 0, 0,0,8'h00));
      tbl.push_back(mk(1,1,1, 1,1, 0,0, 0,0, 0, 0,0,8'h02));
      tbl.push_back(mk(0,0,0, 0,0, 0,0, 1,1, 0, 0,0,8'h00));
      tbl.push_back(mk(0,0,0, 0,0, 0,0, 1,6, 0, 0,1,8'h00));
      tbl.push_back(mk(0,0,0, 0,0, 0,0, 1,6, 1, 0,0,8'h00));
      tbl.push_back(mk(1,1,4, 0,0, 0,0, 0,0, 0, 0,0,8'h10));
      tbl.push_back(mk(1,1,4, 0,0, 0,0, 0,0, 0, 0,0,8'h10));
      tbl.push_back(mk(1,1,7, 0,0, 0,0, 0,0, 0, 0,0,8'h90));
      tbl.push_back(mk(1,1,4, 0,0, 0,0, 0,0, 1, 0,0,8'h00));
      tbl.push_back(mk(1,1,2, 0,0, 0,0, 0,0, 0, 0,0,8'h04));
      tbl.push_back(mk(1,0,0, 0,0, 1,2, 0,0, 0, 1,0,8'h04));
      tbl.push_back(mk(0,0,0, 1,2, 1,2, 1,2, 0, 0,0,8'h00));
      tbl.push_back(mk(1,1,0, 0,0, 0,0, 0,0, 0, 0,0,8'h01));
      tbl.push_back(mk(1,0,0, 1,0, 0,0, 0,0, 0, 1,0,8'h01));
      tbl.push_back(mk(0,0,0, 0,0, 0,0, 1,0, 0, 0,0,8'h00));
      foreach (tbl[i]) step(tbl[i], 1, $sformatf("tbl%0d", i));

      for (int i = 0; i < 3000; i++) begin
         v = mk($urandom_range(0,1), $urandom_range(0,1), 3'($urandom), $urandom_range(0,1), 3'($urandom),
                $urandom_range(0,1), 3'($urandom), $urandom_range(0,1), 3'($urandom),
                $urandom_range(0,31) == 0, 0, 0, 8'h00);
         step(v, 0, $sformatf("rnd%0d", i));
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
